// File: rtl/hps_uart1_rx.sv
// HPS UART1 fabric receiver: 8-bit LSB-first frames, 16x oversampling, FWFT byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames; the default build is 8N1.
module hps_uart1_rx #(
   parameter int unsigned BAUD_DIV = 54,
   parameter int unsigned FIFO_AW  = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_rx,
   output logic [7:0]         o_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic               o_frame_err,
   output logic               o_parity_err,
   output logic               o_overrun,
   output logic [FIFO_AW:0]   o_count
);

   localparam int unsigned DEPTH = 2 ** FIFO_AW;
   localparam int unsigned BW    = $clog2(BAUD_DIV);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic                r_sync1;
   logic                r_rx_s;
   logic                r_rx_q;

   logic [BW-1:0]       r_baud_cnt;
   logic                w_tick;
   logic [3:0]          r_samp;
   logic                w_mid;

   logic [2:0]          r_bit_idx;
   logic [7:0]          r_shift;

   logic                w_start;
   logic                w_shift;
   logic                w_push;
   logic                w_ferr;

   logic                r_frame_err;
   logic                r_overrun;

   logic [7:0]          r_mem [DEPTH];
   logic [FIFO_AW-1:0]  r_wr_ptr;
   logic [FIFO_AW-1:0]  r_rd_ptr;
   logic [FIFO_AW:0]    r_count;
   logic                w_full;
   logic                w_pop;
   logic                w_wr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
         r_rx_q  <= 1'b1;
      end else begin
         r_sync1 <= i_rx;
         r_rx_s  <= r_sync1;
         r_rx_q  <= r_rx_s;
      end
   end

   assign w_tick = (r_baud_cnt == BW'(BAUD_DIV - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_baud_cnt <= '0;
      end else if (w_start || w_tick) begin
         r_baud_cnt <= '0;
      end else begin
         r_baud_cnt <= r_baud_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_samp <= '0;
      end else if (w_next != r_state) begin
         r_samp <= '0;
      end else if (w_tick) begin
         r_samp <= r_samp + 1'b1;
      end
   end

   // Count restarts at the start-bit midpoint, so later mid-bits fall on the 16th tick.
   assign w_mid = w_tick && (r_samp == 4'd15);

`ifdef UART_RX_PARITY_EN
   logic w_perr;
   logic r_par_bad;
   logic r_parity_err;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_shift = 1'b0;
      w_push  = 1'b0;
      w_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_perr  = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (r_rx_q && !r_rx_s) begin
               w_next  = S_START;
               w_start = 1'b1;
            end
         end
         S_START: begin
            if (w_tick && (r_samp == 4'd7)) begin
               w_next = r_rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (w_mid) begin
               w_shift = 1'b1;
               if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  w_next = S_PARITY;
`else
                  w_next = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_mid) begin
               w_next = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (w_mid) begin
               w_next = S_IDLE;
               if (!r_rx_s) begin
                  w_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (r_par_bad) begin
                  w_perr = 1'b1;
`endif
               end else begin
                  w_push = 1'b1;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else if (w_start) begin
         r_bit_idx <= '0;
      end else if (w_shift) begin
         r_shift[r_bit_idx] <= r_rx_s;
         r_bit_idx          <= r_bit_idx + 1'b1;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Even parity: line bit must equal the XOR of the eight data bits.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         r_parity_err <= w_perr;
         if (w_start) begin
            r_par_bad <= 1'b0;
         end else if ((r_state == S_PARITY) && w_mid) begin
            r_par_bad <= r_rx_s ^ (^r_shift);
         end
      end
   end
   assign o_parity_err = r_parity_err;
`else
   assign o_parity_err = 1'b0;
`endif

   assign w_full = (r_count == (FIFO_AW + 1)'(DEPTH));
   assign w_pop  = o_valid && i_ready;
   assign w_wr   = w_push && (!w_full || w_pop);

   always_ff @(posedge i_clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= r_shift;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_ferr;
         r_overrun   <= w_push && w_full && !w_pop;
      end
   end

   assign o_valid     = (r_count != '0);
   assign o_data      = o_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count     = r_count;
   assign o_frame_err = r_frame_err;
   assign o_overrun   = r_overrun;

endmodule
